// File: rtl/fir_pkg.sv
// Shared widths, coefficient-memory geometry and FSM encoding for the FIR MAC engine.
package fir_pkg;
   localparam int DATA_W      = 16;
   localparam int COEF_W      = 16;
   localparam int ACC_W       = 40;
   localparam int CMEM_ADDR_W = 6;
   localparam int CMEM_DEPTH  = 64;
   localparam int PROD_W      = DATA_W + COEF_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      LAST = 2'd2,
      DONE = 2'd3
   } fir_state_e;
endpackage

// File: rtl/fir_mac_engine_if.sv
// Sample stream, result stream and coefficient-memory read port of the FIR engine.
interface fir_mac_engine_if
   import fir_pkg::*;
   ;
   logic                   in_valid;
   logic                   in_ready;
   logic [DATA_W-1:0]      in_data;
   logic                   coef_cen_n;
   logic                   coef_wen_n;
   logic [CMEM_ADDR_W-1:0] coef_addr;
   logic [COEF_W-1:0]      coef_d;
   logic [COEF_W-1:0]      coef_q;
   logic                   out_valid;
   logic                   out_ready;
   logic [ACC_W-1:0]       out_data;
   logic                   busy;

   modport master (
      input  in_valid, in_data, coef_q, out_ready,
      output in_ready, coef_cen_n, coef_wen_n, coef_addr, coef_d,
             out_valid, out_data, busy
   );

   modport slave (
      output in_valid, in_data, coef_q, out_ready,
      input  in_ready, coef_cen_n, coef_wen_n, coef_addr, coef_d,
             out_valid, out_data, busy
   );
endinterface

// File: rtl/fir_sample_buf.sv
// Circular sample history: one register per tap, single write port, combinational read.
module fir_sample_buf #(
   parameter int TAPS   = 64,
   parameter int DATA_W = 16,
   parameter int IDX_W  = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [IDX_W-1:0]  wptr,
   input  logic [DATA_W-1:0] din,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [DATA_W-1:0] dout
);
   logic [DATA_W-1:0] hist [0:TAPS-1];

   genvar gi;
   generate
      for (gi = 0; gi < TAPS; gi++) begin : g_entry
         logic [DATA_W-1:0] entry_reg;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               entry_reg <= '0;
            end else if (we && (wptr == IDX_W'(gi))) begin
               entry_reg <= din;
            end
         end

         assign hist[gi] = entry_reg;
      end
   endgenerate

   assign dout = hist[rd_idx];
endmodule

// File: rtl/fir_mac_engine.sv
// Sequential FIR: one tap per cycle, coefficients streamed from a synchronous-read
// coefficient memory, result held on a valid/ready output.
module fir_mac_engine
   import fir_pkg::*;
#(
   parameter int TAPS = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   fir_mac_engine_if.master   bus
);
   localparam int IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1;

   fir_state_e                state_reg;
   logic [CMEM_ADDR_W-1:0]    k_reg;
   logic [CMEM_ADDR_W-1:0]    kd_reg;
   logic                      rd_d_reg;
   logic [IDX_W-1:0]          wptr_reg;
   logic signed [ACC_W-1:0]   acc_reg;
   logic signed [ACC_W-1:0]   acc_next;
   logic [ACC_W-1:0]          out_data_reg;
   logic                      out_valid_reg;
   logic                      in_ready_reg;
   logic                      busy_reg;

   logic                      hist_we;
   logic [IDX_W-1:0]          rd_idx;
   logic [DATA_W-1:0]         hist_q;
   logic signed [PROD_W-1:0]  prod;
   logic signed [ACC_W-1:0]   prod_ext;

   assign hist_we = in_ready_reg && bus.in_valid;
   // kd is the tap whose coefficient is on coef_q now; pair it with x[n-kd].
   assign rd_idx  = wptr_reg - kd_reg[IDX_W-1:0];

   fir_sample_buf #(
      .TAPS   (TAPS),
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
   ) u_sample_buf (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     (hist_we),
      .wptr   (wptr_reg),
      .din    (bus.in_data),
      .rd_idx (rd_idx),
      .dout   (hist_q)
   );

   assign prod     = PROD_W'($signed(bus.coef_q)) * PROD_W'($signed(hist_q));
   assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

   always_comb begin
      acc_next = acc_reg;
      if (rd_d_reg) begin
         acc_next = acc_reg + prod_ext;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         k_reg         <= '0;
         kd_reg        <= '0;
         rd_d_reg      <= 1'b0;
         wptr_reg      <= '0;
         acc_reg       <= '0;
         out_data_reg  <= '0;
         out_valid_reg <= 1'b0;
         in_ready_reg  <= 1'b1;
         busy_reg      <= 1'b0;
      end else begin
         rd_d_reg <= (state_reg == RUN);
         kd_reg   <= k_reg;
         acc_reg  <= acc_next;
         case (state_reg)
            IDLE: begin
               if (bus.in_valid) begin
                  acc_reg      <= '0;
                  k_reg        <= '0;
                  in_ready_reg <= 1'b0;
                  busy_reg     <= 1'b1;
                  state_reg    <= RUN;
               end
            end
            RUN: begin
               k_reg <= k_reg + CMEM_ADDR_W'(1);
               if (k_reg == CMEM_ADDR_W'(TAPS - 1)) begin
                  state_reg <= LAST;
               end
            end
            LAST: begin
               // Last tap lands here, so the result takes the combinational sum.
               out_data_reg  <= acc_next;
               out_valid_reg <= 1'b1;
               state_reg     <= DONE;
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_reg <= 1'b0;
                  wptr_reg      <= wptr_reg + IDX_W'(1);
                  in_ready_reg  <= 1'b1;
                  busy_reg      <= 1'b0;
                  state_reg     <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.in_ready   = in_ready_reg;
   assign bus.out_valid  = out_valid_reg;
   assign bus.out_data   = out_data_reg;
   assign bus.busy       = busy_reg;
   assign bus.coef_cen_n = (state_reg != RUN);
   assign bus.coef_addr  = (state_reg == RUN) ? k_reg : '0;
   assign bus.coef_wen_n = 1'b1;
   assign bus.coef_d     = '0;
endmodule

// File: tb/tb_fir_mac_engine.sv
// Directed bench for fir_mac_engine with TAPS=4 and a synchronous-read coefficient memory model.
module tb_fir_mac_engine;
   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   logic [15:0] cmem [0:63];

   fir_mac_engine_if bus ();

   fir_mac_engine #(.TAPS(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!bus.coef_cen_n) bus.coef_q <= cmem[bus.coef_addr];
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_coefs(input logic [15:0] c0, input logic [15:0] c1,
                            input logic [15:0] c2, input logic [15:0] c3);
      for (int i = 0; i < 64; i++) cmem[i] = 16'h0000;
      cmem[0] = c0; cmem[1] = c1; cmem[2] = c2; cmem[3] = c3;
   endtask

   task automatic wait_result(input string tag, input logic [39:0] exp);
      int cyc;
      cyc = 0;
      while (!bus.out_valid && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
      check({tag, "_data"}, 64'(bus.out_data), 64'(exp));
   endtask

   // Entered and left on a negedge with the engine idle.
   task automatic do_sample(input string tag, input logic [15:0] x, input logic [39:0] exp);
      bus.in_valid = 1'b1;
      bus.in_data  = x;
      @(negedge clk);
      bus.in_valid = 1'b0;
      check({tag, "_busy"}, 64'(bus.busy), 64'd1);
      wait_result(tag, exp);
      $display("[TB] sample %s x=%h y=%h", tag, x, bus.out_data);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.out_ready = 1'b0;
      set_coefs(16'd1, 16'd2, 16'd3, 16'd4);
      repeat (3) @(negedge clk);
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_cen_n", 64'(bus.coef_cen_n), 64'd1);
      check("rst_wen_n", 64'(bus.coef_wen_n), 64'd1);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_coef_d", 64'(bus.coef_d), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Impulse, first sample with cycle-exact timing
      bus.in_valid = 1'b1;
      bus.in_data  = 16'd1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("t_in_ready", 64'(bus.in_ready), 64'd0);
      check("t_busy", 64'(bus.busy), 64'd1);
      for (int c = 0; c < 4; c++) begin
         check("t_cen_run", 64'(bus.coef_cen_n), 64'd0);
         check("t_addr", 64'(bus.coef_addr), 64'(c));
         check("t_no_valid", 64'(bus.out_valid), 64'd0);
         @(negedge clk);
      end
      check("t_cen_last", 64'(bus.coef_cen_n), 64'd1);
      check("t_valid_last", 64'(bus.out_valid), 64'd0);
      check("t_busy_last", 64'(bus.busy), 64'd1);
      @(negedge clk);
      check("t_valid_done", 64'(bus.out_valid), 64'd1);
      check("imp0_data", 64'(bus.out_data), 64'd1);
      $display("[TB] sample imp0 x=0001 y=%h", bus.out_data);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("t_busy_idle", 64'(bus.busy), 64'd0);
      check("t_in_ready_idle", 64'(bus.in_ready), 64'd1);

      do_sample("imp1", 16'd0, 40'd2);
      do_sample("imp2", 16'd0, 40'd3);
      do_sample("imp3", 16'd0, 40'd4);
      do_sample("imp4", 16'd0, 40'd0);

      // Backpressure: history now ..,0,0,0 then 7
      bus.in_valid = 1'b1;
      bus.in_data  = 16'd7;
      @(negedge clk);
      bus.in_valid = 1'b0;
      wait_result("bp", 40'd7);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'd2;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("bp_valid", 64'(bus.out_valid), 64'd1);
         check("bp_data", 64'(bus.out_data), 64'd7);
         check("bp_in_ready", 64'(bus.in_ready), 64'd0);
         check("bp_cen", 64'(bus.coef_cen_n), 64'd1);
      end
      $display("[TB] sample bp x=0007 y=%h held 10 cycles", bus.out_data);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("bp_rel_in_ready", 64'(bus.in_ready), 64'd1);
      check("bp_rel_busy", 64'(bus.busy), 64'd0);
      check("bp_rel_valid", 64'(bus.out_valid), 64'd0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("bp_acc_busy", 64'(bus.busy), 64'd1);
      check("bp_acc_cen", 64'(bus.coef_cen_n), 64'd0);
      wait_result("bp_next", 40'd16);
      $display("[TB] sample bp_next x=0002 y=%h", bus.out_data);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;

      // Signed full scale from a cleared history
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      set_coefs(16'h8000, 16'h8000, 16'h8000, 16'h8000);
      @(negedge clk);
      do_sample("fs0", 16'h8000, 40'h00_4000_0000);
      do_sample("fs1", 16'h8000, 40'h00_8000_0000);
      do_sample("fs2", 16'h8000, 40'h00_C000_0000);
      do_sample("fs3", 16'h8000, 40'h01_0000_0000);

      // Reset mid-RUN
      set_coefs(16'd1, 16'd2, 16'd3, 16'd4);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'd3;
      @(negedge clk);
      bus.in_valid = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (!bus.coef_cen_n && bus.coef_addr == 6'd2) break;
         @(negedge clk);
      end
      check("mr_addr2", 64'(bus.coef_addr), 64'd2);
      #2 rst_n = 1'b0;
      #1;
      check("mr_in_ready", 64'(bus.in_ready), 64'd1);
      check("mr_out_valid", 64'(bus.out_valid), 64'd0);
      check("mr_out_data", 64'(bus.out_data), 64'd0);
      check("mr_cen", 64'(bus.coef_cen_n), 64'd1);
      check("mr_wen", 64'(bus.coef_wen_n), 64'd1);
      check("mr_busy", 64'(bus.busy), 64'd0);
      check("mr_addr0", 64'(bus.coef_addr), 64'd0);
      $display("[TB] reset mid-RUN applied");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_sample("mr_imp", 16'd5, 40'd5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
